// File: rtl/ram_rc_row_loader_if.sv
// Handshake and RAM-side bus of the ram_rc row loader.
// master = word source / RAM-side consumer, slave = the loader itself.
interface ram_rc_row_loader_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        rnw;
  logic [2:0]  wa;
  logic [2:0]  ra;
  logic [7:0]  be;
  logic [63:0] di;
  logic        din_valid;
  logic        col_valid;
  logic [2:0]  col_idx;
  logic [3:0]  blk_rows;
  logic        block_done;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, rnw, wa, ra, be, di, din_valid,
           col_valid, col_idx, blk_rows, block_done
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, rnw, wa, ra, be, di, din_valid,
           col_valid, col_idx, blk_rows, block_done
  );
endinterface

// File: rtl/ram_rc_row_loader.sv
// Packs 32-bit words into 64-bit rows, writes them into the 8x8 transpose
// RAM, then sweeps the column address and flags each column on RAM do.
module ram_rc_row_loader (
  input logic               clk,
  input logic               rst,
  ram_rc_row_loader_if.slave bus
);
  typedef enum logic [1:0] {FILL, FLUSH, READ, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic        half_q, half_d;
  logic [31:0] hold_q, hold_d;
  logic        rnw_q, rnw_d;
  logic [2:0]  wa_q, wa_d;
  logic [2:0]  ra_q, ra_d;
  logic [7:0]  be_q, be_d;
  logic [63:0] di_q, di_d;
  logic        dv_q, dv_d;
  logic        cv_q, cv_d;
  logic [2:0]  cidx_q, cidx_d;
  logic [3:0]  blk_q, blk_d;
  logic        bd_q, bd_d;
  logic        accept;

  assign accept       = bus.in_valid && (state_q == FILL);
  assign bus.in_ready = (state_q == FILL) && !rst;

  assign bus.rnw        = rnw_q;
  assign bus.wa         = wa_q;
  assign bus.ra         = ra_q;
  assign bus.be         = be_q;
  assign bus.di         = di_q;
  assign bus.din_valid  = dv_q;
  assign bus.col_valid  = cv_q;
  assign bus.col_idx    = cidx_q;
  assign bus.blk_rows   = blk_q;
  assign bus.block_done = bd_q;

  // Next-state and registered-output decode; strobes default low, be to FF.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    half_d  = half_q;
    hold_d  = hold_q;
    wa_d    = wa_q;
    ra_d    = ra_q;
    di_d    = di_q;
    be_d    = 8'hFF;
    dv_d    = 1'b0;
    cv_d    = 1'b0;
    cidx_d  = cidx_q;
    blk_d   = blk_q;
    bd_d    = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (!half_q) begin
            hold_d = bus.in_data;
            half_d = 1'b1;
            if (bus.in_last) begin
              dv_d    = 1'b1;
              be_d    = 8'h0F;
              wa_d    = row_q;
              di_d    = {bus.in_data, 32'h0};
              blk_d   = {1'b0, row_q} + 4'd1;
              state_d = FLUSH;
            end
          end else begin
            dv_d   = 1'b1;
            be_d   = 8'h00;
            wa_d   = row_q;
            di_d   = {hold_q, bus.in_data};
            row_d  = row_q + 3'd1;
            half_d = 1'b0;
            if ((row_q == 3'd7) || bus.in_last) begin
              blk_d   = {1'b0, row_q} + 4'd1;
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        ra_d    = '0;
        state_d = READ;
      end
      READ: begin
        // do is registered in the RAM, so the column for ra appears next cycle
        cv_d   = 1'b1;
        cidx_d = ra_q;
        ra_d   = ra_q + 3'd1;
        if (ra_q == 3'd7) begin
          bd_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        row_d   = '0;
        half_d  = 1'b0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    rnw_d = (state_d == FILL) || (state_d == FLUSH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      row_q   <= '0;
      half_q  <= 1'b0;
      hold_q  <= '0;
      rnw_q   <= 1'b1;
      wa_q    <= '0;
      ra_q    <= '0;
      be_q    <= '1;
      di_q    <= '0;
      dv_q    <= 1'b0;
      cv_q    <= 1'b0;
      cidx_q  <= '0;
      blk_q   <= '0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      half_q  <= half_d;
      hold_q  <= hold_d;
      rnw_q   <= rnw_d;
      wa_q    <= wa_d;
      ra_q    <= ra_d;
      be_q    <= be_d;
      di_q    <= di_d;
      dv_q    <= dv_d;
      cv_q    <= cv_d;
      cidx_q  <= cidx_d;
      blk_q   <= blk_d;
      bd_q    <= bd_d;
    end
  end
endmodule

// File: tb/tb_ram_rc_row_loader.sv
// Bench for ram_rc_row_loader: cycle-offset reference model plus directed
// blocks with hand-computed write/timing expectations.
module tb_ram_rc_row_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_rc_row_loader_if bus ();
  ram_rc_row_loader dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [2:0]  wa;
    logic [7:0]  be;
    logic [63:0] di;
  } wr_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  wr_t wlog[$];
  int  acc_q[$];
  int  bd_q[$];

  // reference model state: m_k = cycles since the block-ending edge (0 = filling)
  int          m_k = 0;
  int          m_words = 0;
  logic [31:0] m_hold = '0;
  bit          m_live = 0;
  bit          chk_all = 0;
  logic        e_rnw, e_dv, e_cv, e_bd;
  logic [2:0]  e_wa, e_ra, e_cidx;
  logic [7:0]  e_be;
  logic [63:0] e_di;
  logic [3:0]  e_blk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: expected outputs for the cycle after each edge.
  always @(posedge clk) begin
    int idx, row;
    chk_all = 0;
    if (rst) begin
      m_k = 0; m_words = 0; m_live = 1; chk_all = 1;
      e_rnw = 1; e_be = 8'hFF; e_wa = 0; e_ra = 0; e_di = 0; e_dv = 0;
      e_cv = 0; e_cidx = 0; e_blk = 0; e_bd = 0;
    end else if (m_live) begin
      e_dv = 0; e_be = 8'hFF; e_cv = 0; e_bd = 0;
      if (m_k == 0) begin
        if (bus.in_valid) begin
          idx = m_words;
          row = idx / 2;
          if (idx % 2 == 0) begin
            m_hold = bus.in_data;
            if (bus.in_last) begin
              e_dv = 1; e_be = 8'h0F; e_wa = 3'(row);
              e_di = {bus.in_data, 32'h0}; e_blk = 4'(row + 1); m_k = 1;
            end
          end else begin
            e_dv = 1; e_be = 8'h00; e_wa = 3'(row);
            e_di = {m_hold, bus.in_data};
            if (bus.in_last || row == 7) begin
              e_blk = 4'(row + 1); m_k = 1;
            end
          end
          m_words++;
        end
      end else if (m_k == 10) begin
        m_k = 0; m_words = 0;
      end else begin
        m_k++;
      end
      e_rnw = (m_k <= 1);
      if (m_k >= 2 && m_k <= 9) e_ra = 3'(m_k - 2);
      if (m_k >= 3 && m_k <= 10) begin e_cv = 1; e_cidx = 3'(m_k - 3); end
      e_bd = (m_k == 10);
    end
  end

  // Compare process plus write/acceptance/done logging, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", bus.in_ready, (m_k == 0) && !rst);
      chk("rnw", bus.rnw, e_rnw);
      chk("din_valid", bus.din_valid, e_dv);
      chk("be", bus.be, e_be);
      chk("col_valid", bus.col_valid, e_cv);
      chk("block_done", bus.block_done, e_bd);
      chk("blk_rows", bus.blk_rows, e_blk);
      if (e_dv || chk_all) begin
        chk("wa", bus.wa, e_wa);
        chk("di", bus.di, e_di);
      end
      if (e_cv || chk_all) chk("col_idx", bus.col_idx, e_cidx);
      if ((m_k >= 2 && m_k <= 9) || chk_all) chk("ra", bus.ra, e_ra);
    end
    if (bus.din_valid) wlog.push_back('{wa: bus.wa, be: bus.be, di: bus.di});
    if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    if (bus.block_done) bd_q.push_back(cyc);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    int   tries;
    logic acc;
    bus.in_data = d; bus.in_last = last; bus.in_valid = 1'b1; tries = 0;
    do begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1; tries++;
    end while (!acc && tries < 40);
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: got no accept expected accept (cycle %0d)", cyc);
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic run_block(input int n, input int last_idx, input int gap);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = 8'(k);
      push({4{b}}, k == last_idx);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic clr_logs();
    wlog.delete(); acc_q.delete(); bd_q.delete();
  endtask

  task automatic check_full_writes(input string tag);
    chk({tag, "_nwr"}, wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk({tag, "_w0_di"}, wlog[0].di, 64'h00000000_01010101);
      chk({tag, "_w0_be"}, wlog[0].be, 8'h00);
      chk({tag, "_w7_wa"}, wlog[7].wa, 3'd7);
      chk({tag, "_w7_di"}, wlog[7].di, 64'h0E0E0E0E_0F0F0F0F);
      chk({tag, "_w3_di"}, wlog[3].di, 64'h06060606_07070707);
    end
    chk({tag, "_blk"}, bus.blk_rows, 4'd8);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
    idle(2);
    chk("rst_be", bus.be, 8'hFF);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    idle(2);

    // full block, gap-free
    clr_logs();
    run_block(16, -1, 0);
    idle(12);
    check_full_writes("full");
    chk("full_nacc", acc_q.size(), 16);
    chk("full_nbd", bd_q.size(), 1);
    if (acc_q.size() == 16 && bd_q.size() == 1)
      chk("full_done_lat", bd_q[0] - acc_q[15], 10);

    // early end on a first half (row 2)
    clr_logs();
    run_block(5, 4, 0);
    idle(12);
    chk("e1_nwr", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("e1_wa", wlog[2].wa, 3'd2);
      chk("e1_be", wlog[2].be, 8'h0F);
      chk("e1_di", wlog[2].di, 64'h04040404_00000000);
    end
    chk("e1_blk", bus.blk_rows, 4'd3);

    // early end on a second half (row 1)
    clr_logs();
    run_block(4, 3, 0);
    idle(12);
    chk("e2_nwr", wlog.size(), 2);
    if (wlog.size() == 2) chk("e2_di", wlog[1].di, 64'h02020202_03030303);
    chk("e2_blk", bus.blk_rows, 4'd2);

    // bubbles: valid pattern 1,0,0,1,0,0,...
    clr_logs();
    run_block(16, -1, 2);
    idle(12);
    check_full_writes("bub");

    // reset while ra = 4
    clr_logs();
    run_block(16, -1, 0);
    idle(4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rr_ra", bus.ra, 3'd4);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rr_col_valid", bus.col_valid, 1'b0);
    chk("rr_rnw", bus.rnw, 1'b1);
    chk("rr_in_ready", bus.in_ready, 1'b1);
    chk("rr_nbd", bd_q.size(), 0);
    @(posedge clk); #1;
    clr_logs();
    run_block(16, -1, 0);
    idle(12);
    check_full_writes("post_rst");

    // back-to-back blocks, second stream held valid during the busy window
    clr_logs();
    run_block(16, -1, 0);
    run_block(16, -1, 0);
    idle(12);
    chk("b2b_nacc", acc_q.size(), 32);
    chk("b2b_nbd", bd_q.size(), 2);
    if (acc_q.size() == 32) chk("b2b_gap", acc_q[16] - acc_q[15], 11);
    if (acc_q.size() == 32 && bd_q.size() == 2) begin
      chk("b2b_done0", bd_q[0] - acc_q[15], 10);
      chk("b2b_done1", bd_q[1] - acc_q[31], 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
